alu_seq: RTL and testbench
==========================

# alu_seq

Sequenced execute-stage ALU that consumes the 4-bit `alu_ctrl` code from the ALU control decoder, together with the two register-file/immediate operands. Single-cycle ops (ADD, SUB, AND, OR, SLT) return a registered result one cycle after `start`. An optional unsigned shift-add multiplier runs over WIDTH cycles behind a ready/start/done handshake. The block replaces the purely combinational ALU so that a multi-cycle multiply can stall the datapath.

## Interface
- `WIDTH`, default 32: operand and result width. Legal range is 8 to 64.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: request. Sampled only when `ready`=1.
- `alu_ctrl`  in  4: operation code from the ALU control decoder.
- `a`  in  WIDTH: operand A, the rs value.
- `b`  in  WIDTH: operand B, the rt value or immediate.
- `ready`  out  1: block is idle and accepts `start`.
- `done`  out  1: single-cycle pulse; `result`, `hi`, `zero` and `illegal` are valid.
- `result`  out  WIDTH: result, or low half of the product.
- `hi`  out  WIDTH: high half of the product; 0 for non-multiply ops.
- `zero`  out  1: `result`==0. Low half only.
- `illegal`  out  1: the operation code is unsupported.

## Operation
- Op codes:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 4 AND: a&b.
  - 5 OR: a|b.
  - 7 SLT: signed a<b gives 1, else 0.
  - 8 MULTU: unsigned a×b, 2·WIDTH-bit product split into {hi,result}.
- Any other code, including X/Z, is illegal: `result`=0, `hi`=0, `zero`=1, `illegal`=1.
- ADD and SUB wrap modulo 2^WIDTH. No overflow flag.
- States:
  - IDLE: `ready`=1.
  - MUL: `ready`=0.
- IDLE with `start`=1 and a single-cycle or illegal code:
  - Outputs are registered at that edge and `done`=1 for the following cycle.
  - The block stays in IDLE, so back-to-back starts sustain one op per cycle.
- IDLE with `start`=1 and code 8:
  - Operands are latched, the accumulator is cleared, the iteration counter is set to 0, and the state moves to MUL.
- In MUL:
  - One multiplier bit is processed per cycle, LSB first, as a shift-add into a 2·WIDTH accumulator.
  - After WIDTH iterations the state returns to IDLE with {hi,result} loaded and `done`=1.
- `start` while `ready`=0 is ignored. It is neither queued nor an error.
- `start` in the same cycle that `done`=1 is accepted, because `ready` is already 1.
- `a`, `b` and `alu_ctrl` may change freely after the accepting edge; latched copies are used.
- `result`, `hi`, `zero` and `illegal` hold their values until the next `done`.

## Timing
- Reset, asynchronous: state=IDLE, `ready`=1, `done`=0, `result`=0, `hi`=0, `zero`=0, `illegal`=0. The iteration counter and accumulator are cleared.
- Reset mid-multiply aborts the operation. No `done` is produced.
- Single-cycle latency: `start` sampled at edge E gives `done`=1 in the cycle after E.
- Multiply latency: `start` at edge E gives `ready`=0 from E until `done` is registered at edge E+WIDTH.
  - `done`=1 and `ready`=1 hold in the cycle after E+WIDTH.
  - Example: with WIDTH=32, 32 cycles from accept to `done`.
- `done` is high for exactly one cycle per accepted `start`.
- All outputs are registered. There are no combinational paths from inputs to outputs, except that `ready` is decoded from state only.

## Configuration
- `ALU_MUL_EN` defined:
  - The MUL state, accumulator and counter are compiled in.
  - Code 8 behaves as described above.
- `ALU_MUL_EN` undefined:
  - There is no MUL state, and `ready` is tied to 1.
  - Code 8 is illegal: `done` after 1 cycle with `illegal`=1.
  - `hi` is tied to 0.

## Test plan
- ADD: a=7, b=5, `alu_ctrl`=0, `start`=1 for 1 cycle → next cycle `done`=1, `result`=12, `zero`=0, `hi`=0.
- SUB wrap and zero flag:
  - SUB 5−5 → `result`=0, `zero`=1.
  - Back-to-back SUB 0−1 → `result`=0xFFFFFFFF, `done` on two consecutive cycles.
- SLT signed: a=0xFFFFFFFF, b=1 → `result`=1. Swap the operands → `result`=0.
- MULTU, with `ALU_MUL_EN` defined: a=0xFFFFFFFF, b=2.
  - `ready`=0 for 32 cycles.
  - Extra `start` pulses during busy are ignored.
  - Then `done`=1 with `hi`=1 and `result`=0xFFFFFFFE.
- Reset at cycle 10 of a multiply → `ready`=1, `done`=0, `result`=0. A following ADD 1+1 → `result`=2 after 1 cycle.
- Illegal code: `alu_ctrl`=4'hF, or code 8 with `ALU_MUL_EN` undefined → 1 cycle later `done`=1, `illegal`=1, `result`=0, `zero`=1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequenced execute-stage ALU: single-cycle ADD/SUB/AND/OR/SLT plus an optional
// WIDTH-cycle unsigned shift-add multiplier, compiled in when ALU_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd7;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MULTU = 4'd8;
`endif

    logic [WIDTH-1:0]        w_res;
    logic                    w_legal;
    logic signed [WIDTH-1:0] w_sa;
    logic signed [WIDTH-1:0] w_sb;

    logic [WIDTH-1:0]        r_result;
    logic                    r_done;
    logic                    r_zero;
    logic                    r_illegal;

`ifdef ALU_MUL_EN
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]     w_acc_nxt;
    logic [WIDTH-1:0]       r_mplier;
    logic [WIDTH-1:0]       r_hi;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_is_mul;
    logic                   w_last;
`endif

    assign w_sa = a;
    assign w_sb = b;

    // Unsupported codes leave w_res at zero, which also yields zero=1.
    always_comb begin
        w_res   = '0;
        w_legal = 1'b1;
`ifdef ALU_MUL_EN
        w_is_mul = 1'b0;
`endif
        case (alu_ctrl)
            OP_ADD:   w_res = a + b;
            OP_SUB:   w_res = a - b;
            OP_AND:   w_res = a & b;
            OP_OR:    w_res = a | b;
            OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, (w_sa < w_sb)};
`ifdef ALU_MUL_EN
            OP_MULTU: w_is_mul = 1'b1;
`endif
            default:  w_legal = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_MUL_EN
            r_hi      <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef ALU_MUL_EN
            // One multiplier bit per cycle, LSB first; multiplicand shifts up each step.
            if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_done    <= 1'b1;
                    r_result  <= w_acc_nxt[WIDTH-1:0];
                    r_hi      <= w_acc_nxt[2*WIDTH-1:WIDTH];
                    r_zero    <= (w_acc_nxt[WIDTH-1:0] == '0);
                    r_illegal <= 1'b0;
                end
            end else if (start && w_is_mul) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_cnt    <= '0;
            end else
`endif
            if (start) begin
                r_done    <= 1'b1;
                r_result  <= w_res;
                r_zero    <= (w_res == '0);
                r_illegal <= ~w_legal;
`ifdef ALU_MUL_EN
                r_hi      <= '0;
`endif
            end
        end
    end

`ifdef ALU_MUL_EN
    assign ready = (r_state == S_IDLE);
    assign hi    = r_hi;
`else
    assign ready = 1'b1;
    assign hi    = '0;
`endif
    assign done    = r_done;
    assign result  = r_result;
    assign zero    = r_zero;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a result scoreboard; multiply checks are
// selected by ALU_MUL_EN, otherwise code 8 is checked as illegal.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;
    logic         illegal;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .zero     (zero),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.tag = "rand";
        e.hi  = '0;
        e.ill = 1'b0;
        case (c)
            4'd0:    e.res = x + y;
            4'd1:    e.res = x - y;
            4'd4:    e.res = x & y;
            4'd5:    e.res = x | y;
            4'd7:    e.res = ($signed(x) < $signed(y)) ? 1 : 0;
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Drive one single-cycle request at a falling edge and check done one cycle later.
    task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                         input exp_t e);
        start    = 1'b1;
        alu_ctrl = c;
        a        = x;
        b        = y;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk({e.tag, "_done"}, done, 1);
        chk({e.tag, "_ready"}, ready, 1);
    endtask

    function automatic exp_t mk(input string t, input logic [W-1:0] r, input logic [W-1:0] h,
                                input logic z, input logic il);
        exp_t e;
        e.tag = t; e.res = r; e.hi = h; e.zero = z; e.ill = il;
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            chk("sb_expected_pending", (q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, "_result"},  result,  e.res);
                chk({e.tag, "_hi"},      hi,      e.hi);
                chk({e.tag, "_zero"},    zero,    e.zero);
                chk({e.tag, "_illegal"}, illegal, e.ill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; alu_ctrl = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready",   ready,   1);
        chk("rst_done",    done,    0);
        chk("rst_result",  result,  0);
        chk("rst_hi",      hi,      0);
        chk("rst_zero",    zero,    0);
        chk("rst_illegal", illegal, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(4'd0, 32'd7, 32'd5, mk("add", 32'd12, 0, 0, 0));
        @(negedge clk);
        chk("add_done_one_cycle", done, 0);
        chk("add_hold_result", result, 32'd12);

        issue(4'd1, 32'd5, 32'd5, mk("sub_zero", 32'd0, 0, 1, 0));
        issue(4'd1, 32'd0, 32'd1, mk("sub_wrap1", 32'hFFFF_FFFF, 0, 0, 0));
        issue(4'd1, 32'd0, 32'd1, mk("sub_wrap2", 32'hFFFF_FFFF, 0, 0, 0));
        @(negedge clk);
        chk("b2b_done_low", done, 0);

        issue(4'd7, 32'hFFFF_FFFF, 32'd1, mk("slt_neg", 32'd1, 0, 0, 0));
        issue(4'd7, 32'd1, 32'hFFFF_FFFF, mk("slt_pos", 32'd0, 0, 1, 0));
        issue(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, mk("and", 32'hF000_F000, 0, 0, 0));
        issue(4'd5, 32'hF0F0_0000, 32'h0000_0F0F, mk("or", 32'hF0F0_0F0F, 0, 0, 0));
        issue(4'hF, 32'd3, 32'd4, mk("ill_f", 32'd0, 0, 1, 1));
        issue(4'd2, 32'd3, 32'd4, mk("ill_2", 32'd0, 0, 1, 1));
        issue(4'd0, 32'hFFFF_FFFF, 32'd1, mk("add_wrap", 32'd0, 0, 1, 0));

`ifdef ALU_MUL_EN
        start = 1'b1; alu_ctrl = 4'd8; a = 32'hFFFF_FFFF; b = 32'd2;
        q.push_back(mk("multu", 32'hFFFF_FFFE, 32'd1, 0, 0));
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 10);
            alu_ctrl = 4'd0; a = 32'd1; b = 32'd1;
            chk($sformatf("mul_busy_ready_%0d", i), ready, 0);
            chk($sformatf("mul_busy_done_%0d", i), done, 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("mul_done", done, 1);
        chk("mul_ready", ready, 1);
        issue(4'd0, 32'd3, 32'd4, mk("add_on_done", 32'd7, 0, 0, 0));

        start = 1'b1; alu_ctrl = 4'd8; a = 32'd5; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mul_abort_busy", ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready",  ready,  1);
        chk("abort_done",   done,   0);
        chk("abort_result", result, 0);
        chk("abort_hi",     hi,     0);
        @(negedge clk);
        rst = 1'b0;
        issue(4'd0, 32'd1, 32'd1, mk("add_after_abort", 32'd2, 0, 0, 0));
`else
        issue(4'd8, 32'hFFFF_FFFF, 32'd2, mk("multu_ill", 32'd0, 0, 1, 1));
        chk("nomul_ready", ready, 1);
        issue(4'd0, 32'd9, 32'd9, mk("add_pre_rst", 32'd18, 0, 0, 0));
        #2 rst = 1'b1;
        #1;
        chk("arst_ready",  ready,  1);
        chk("arst_done",   done,   0);
        chk("arst_result", result, 0);
        chk("arst_zero",   zero,   0);
        @(negedge clk);
        rst = 1'b0;
        issue(4'd0, 32'd1, 32'd1, mk("add_after_rst", 32'd2, 0, 0, 0));
`endif

        for (int i = 0; i < 10; i++) begin
            logic [3:0]   c;
            logic [W-1:0] x;
            logic [W-1:0] y;
            int           sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: c = 4'd0;
                1: c = 4'd1;
                2: c = 4'd4;
                3: c = 4'd5;
                4: c = 4'd7;
                default: c = 4'd6;
            endcase
            x = $urandom;
            y = (i == 0) ? x : $urandom;
            issue(c, x, y, model(c, x, y));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
